// File: rtl/axi4_lite_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_if
//
// Purpose
//   Registered AXI4-Lite link stage between one MMR master (s_* ports) and one
//   MMR slave (m_* ports). Each of the five channels passes through its own
//   2-entry skid buffer (axi4_lite_skid). Every valid, ready and payload signal
//   leaving this block comes straight from a flop, so the master-side and
//   slave-side timing paths are fully decoupled. Each channel sustains one beat
//   per cycle. Beats are never reordered, dropped or altered.
//
// Handshake rule (all channels, both sides)
//   A beat moves on a rising aclk edge where valid and ready are both 1. The
//   source keeps valid high and the payload unchanged until that edge. The sink
//   may drive ready independently of valid.
//
// Parameters
//   AW  address width (awaddr / araddr)
//   DW  data width (wdata / rdata). Must be a multiple of 8. Strobe width is DW/8.
//
// Ports
//   aclk, areset        clock and synchronous active-high reset
//   s_aw* / m_aw*       write address channel, master -> slave
//   s_w*  / m_w*        write data + strobes, master -> slave
//   s_b*  / m_b*        write response, slave -> master
//   s_ar* / m_ar*       read address channel, master -> slave
//   s_r*  / m_r*        read data + response, slave -> master
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// axi4_lite_skid
//
// Purpose
//   One fully registered 2-entry skid buffer. MAIN holds the beat on the output.
//   SKID catches the beat that was accepted while the output was stalled. Because
//   ready_o is a flop, the stage commits to one extra beat before it knows about
//   the stall. SKID is that extra entry.
//
// Ports
//   clk_i, rst_i              clock and synchronous active-high reset
//   valid_i, ready_o, pay_i   upstream (input) side
//   valid_o, ready_i, pay_o   downstream (output) side
// -----------------------------------------------------------------------------
module axi4_lite_skid #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] pay_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] pay_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t         state_q;
    logic           valid_q;
    logic           ready_q;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;

    logic           in_fire;
    logic           out_fire;

    assign in_fire  = valid_i & ready_q;
    assign out_fire = valid_q & ready_i;

    assign valid_o  = valid_q;
    assign ready_o  = ready_q;
    assign pay_o    = main_q;

    // valid_q and ready_q are registered copies of the state decode:
    // EMPTY -> (0,1), ONE -> (1,1), TWO -> (1,0). They are updated together
    // with state_q, so they never disagree with it. After reset the slice
    // is EMPTY with ready_q=0. The first edge without reset raises ready_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    ready_q <= 1'b1;
                    if (in_fire) begin
                        main_q  <= pay_i;
                        valid_q <= 1'b1;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        // Output stalled and a new beat arrived. Park it.
                        skid_q  <= pay_i;
                        ready_q <= 1'b0;
                        state_q <= ST_TWO;
                    end else if (out_fire && !in_fire) begin
                        valid_q <= 1'b0;
                        state_q <= ST_EMPTY;
                    end else if (in_fire && out_fire) begin
                        // Pass-through. The old beat leaves and the new one takes its place.
                        main_q  <= pay_i;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= ST_ONE;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

module axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              aclk,
    input  logic              areset,

    // Write address: master -> slave
    input  logic [AW-1:0]     s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    output logic [AW-1:0]     m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,

    // Write data: master -> slave
    input  logic [DW-1:0]     s_wdata,
    input  logic [DW/8-1:0]   s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,

    // Write response: slave -> master
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,

    // Read address: master -> slave
    input  logic [AW-1:0]     s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [AW-1:0]     m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,

    // Read data: slave -> master
    output logic [DW-1:0]     s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [DW-1:0]     m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int SW = DW / 8;

    // W carries {strobe, data} and R carries {resp, data} as one payload word.
    // This keeps the two fields of a beat together.
    logic [SW+DW-1:0] w_pay_in;
    logic [SW+DW-1:0] w_pay_out;
    logic [DW+1:0]    r_pay_in;
    logic [DW+1:0]    r_pay_out;

    assign w_pay_in = {s_wstrb, s_wdata};
    assign m_wstrb  = w_pay_out[SW+DW-1:DW];
    assign m_wdata  = w_pay_out[DW-1:0];

    assign r_pay_in = {m_rresp, m_rdata};
    assign s_rresp  = r_pay_out[DW+1:DW];
    assign s_rdata  = r_pay_out[DW-1:0];

    // AW and W use independent slices. The slave pairs address with data.
    axi4_lite_skid #(.W(AW)) u_aw (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (s_awvalid),
        .ready_o (s_awready),
        .pay_i   (s_awaddr),
        .valid_o (m_awvalid),
        .ready_i (m_awready),
        .pay_o   (m_awaddr)
    );

    axi4_lite_skid #(.W(SW+DW)) u_w (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (s_wvalid),
        .ready_o (s_wready),
        .pay_i   (w_pay_in),
        .valid_o (m_wvalid),
        .ready_i (m_wready),
        .pay_o   (w_pay_out)
    );

    axi4_lite_skid #(.W(2)) u_b (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (m_bvalid),
        .ready_o (m_bready),
        .pay_i   (m_bresp),
        .valid_o (s_bvalid),
        .ready_i (s_bready),
        .pay_o   (s_bresp)
    );

    axi4_lite_skid #(.W(AW)) u_ar (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (s_arvalid),
        .ready_o (s_arready),
        .pay_i   (s_araddr),
        .valid_o (m_arvalid),
        .ready_i (m_arready),
        .pay_o   (m_araddr)
    );

    axi4_lite_skid #(.W(DW+2)) u_r (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (m_rvalid),
        .ready_o (m_rready),
        .pay_i   (r_pay_in),
        .valid_o (s_rvalid),
        .ready_i (s_rready),
        .pay_o   (r_pay_out)
    );

endmodule

// File: tb/tb_axi4_lite_if.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_if
//
// Directed bench for axi4_lite_if. The bench plays both the master and the
// slave. Inputs change 1 time unit after a rising edge. Outputs are sampled at
// that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_axi4_lite_if;

    localparam int AW = 32;
    localparam int DW = 32;

    logic              aclk;
    logic              areset;
    logic [AW-1:0]     s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [AW-1:0]     m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [AW-1:0]     s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [AW-1:0]     m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;

    int errors = 0;
    int checks = 0;

    axi4_lite_if #(.AW(AW), .DW(DW)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        areset    = 1'b1;
        s_awaddr  = '0; s_awvalid = 1'b0;
        s_wdata   = '0; s_wstrb   = '0;  s_wvalid = 1'b0;
        s_bready  = 1'b1;
        s_araddr  = '0; s_arvalid = 1'b0;
        s_rready  = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bresp   = '0; m_bvalid = 1'b0;
        m_rdata   = '0; m_rresp  = '0; m_rvalid = 1'b0;
        step();
        step();
        checks++; if ({m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid} !== 5'b0) begin errors++; $display("FAIL reset_valids: got %b expected 00000", {m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}); end
        checks++; if ({s_awready, s_wready, m_bready, s_arready, m_rready} !== 5'b0) begin errors++; $display("FAIL reset_readies_low: got %b expected 00000", {s_awready, s_wready, m_bready, s_arready, m_rready}); end
        checks++; if ({m_awaddr, m_wdata, s_rdata} !== 96'h0) begin errors++; $display("FAIL reset_payload: got %h expected 0", {m_awaddr, m_wdata, s_rdata}); end
        areset = 1'b0;
        step();
        checks++; if ({s_awready, s_wready, m_bready, s_arready, m_rready} !== 5'b11111) begin errors++; $display("FAIL reset_readies_high: got %b expected 11111", {s_awready, s_wready, m_bready, s_arready, m_rready}); end
    endtask

    task automatic test_write();
        s_awaddr = 32'h10; s_awvalid = 1'b1;
        s_wdata  = 32'h15; s_wstrb   = 4'hF; s_wvalid = 1'b1;
        step();
        checks++; if ({m_awvalid, m_awaddr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL write_aw: got v=%b a=%h expected v=1 a=00000010", m_awvalid, m_awaddr); end
        checks++; if ({m_wvalid, m_wstrb, m_wdata} !== {1'b1, 4'hF, 32'h15}) begin errors++; $display("FAIL write_w: got v=%b s=%h d=%h expected v=1 s=f d=00000015", m_wvalid, m_wstrb, m_wdata); end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        // Slave answers the write.
        m_bresp = 2'b00; m_bvalid = 1'b1;
        step();
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) begin errors++; $display("FAIL write_b: got v=%b r=%b expected v=1 r=00", s_bvalid, s_bresp); end
        checks++; if ({m_awvalid, m_wvalid} !== 2'b00) begin errors++; $display("FAIL write_aw_drained: got %b expected 00", {m_awvalid, m_wvalid}); end
        m_bvalid = 1'b0;
        step();
        checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL write_b_once: got %b expected 0", s_bvalid); end
    endtask

    task automatic test_read();
        s_araddr = 32'h0; s_arvalid = 1'b1;
        step();
        checks++; if ({m_arvalid, m_araddr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL read_ar: got v=%b a=%h expected v=1 a=00000000", m_arvalid, m_araddr); end
        s_arvalid = 1'b0;
        m_rdata = 32'h1; m_rresp = 2'b00; m_rvalid = 1'b1;
        step();
        checks++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'h1}) begin errors++; $display("FAIL read_r: got v=%b r=%b d=%h expected v=1 r=00 d=00000001", s_rvalid, s_rresp, s_rdata); end
        m_rvalid = 1'b0;
        step();
        checks++; if ({s_rvalid, m_arvalid} !== 2'b00) begin errors++; $display("FAIL read_r_once: got %b expected 00", {s_rvalid, m_arvalid}); end
    endtask

    task automatic test_aw_stall();
        m_awready = 1'b0;
        s_awaddr = 32'h14; s_awvalid = 1'b1;
        step();
        checks++; if ({m_awvalid, m_awaddr, s_awready} !== {1'b1, 32'h14, 1'b1}) begin errors++; $display("FAIL stall_one: got v=%b a=%h rdy=%b expected v=1 a=00000014 rdy=1", m_awvalid, m_awaddr, s_awready); end
        s_awaddr = 32'h18;
        step();
        checks++; if ({m_awvalid, m_awaddr, s_awready} !== {1'b1, 32'h14, 1'b0}) begin errors++; $display("FAIL stall_two: got v=%b a=%h rdy=%b expected v=1 a=00000014 rdy=0", m_awvalid, m_awaddr, s_awready); end
        s_awvalid = 1'b0; s_awaddr = 32'hFFFF_FFFF;
        step();
        checks++; if ({m_awvalid, m_awaddr, s_awready} !== {1'b1, 32'h14, 1'b0}) begin errors++; $display("FAIL stall_hold: got v=%b a=%h rdy=%b expected v=1 a=00000014 rdy=0", m_awvalid, m_awaddr, s_awready); end
        m_awready = 1'b1;
        step();
        checks++; if ({m_awvalid, m_awaddr, s_awready} !== {1'b1, 32'h18, 1'b1}) begin errors++; $display("FAIL stall_second: got v=%b a=%h rdy=%b expected v=1 a=00000018 rdy=1", m_awvalid, m_awaddr, s_awready); end
        step();
        checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b expected 0", m_awvalid); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] exp_a;
        int            beats;
        beats = 0;
        m_arready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_araddr  = 32'h100 + 32'(i * 4);
            s_arvalid = 1'b1;
            exp_q.push_back(s_araddr);
            checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, s_arready); end
            step();
            // Every cycle must present the next beat in order. A bubble shows up as m_arvalid=0.
            exp_a = exp_q.pop_front();
            checks++; if ({m_arvalid, m_araddr} !== {1'b1, exp_a}) begin errors++; $display("FAIL stream_beat[%0d]: got v=%b a=%h expected v=1 a=%h", i, m_arvalid, m_araddr, exp_a); end
            if (m_arvalid === 1'b1) beats++;
        end
        s_arvalid = 1'b0;
        step();
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b expected 0", m_arvalid); end
        checks++; if (beats !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", beats); end
    endtask

    task automatic test_reset_mid();
        s_rready = 1'b0;
        m_rdata = 32'hA; m_rresp = 2'b00; m_rvalid = 1'b1;
        step();
        m_rdata = 32'hB;
        step();
        checks++; if ({m_rready, s_rvalid, s_rdata} !== {1'b0, 1'b1, 32'hA}) begin errors++; $display("FAIL mid_two: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=0000000a", m_rready, s_rvalid, s_rdata); end
        m_rvalid = 1'b0;
        areset = 1'b1;
        step();
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b expected 0", s_rvalid); end
        checks++; if ({s_awready, s_wready, s_arready, m_bready, m_rready} !== 5'b0) begin errors++; $display("FAIL mid_readies_low: got %b expected 00000", {s_awready, s_wready, s_arready, m_bready, m_rready}); end
        checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL mid_payload: got %h expected 00000000", s_rdata); end
        areset = 1'b0;
        s_rready = 1'b1;
        step();
        checks++; if ({s_awready, s_wready, s_arready, m_bready, m_rready} !== 5'b11111) begin errors++; $display("FAIL mid_readies_high: got %b expected 11111", {s_awready, s_wready, s_arready, m_bready, m_rready}); end
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", s_rvalid); end
        // A fresh read after reset.
        s_araddr = 32'h20; s_arvalid = 1'b1;
        step();
        checks++; if ({m_arvalid, m_araddr} !== {1'b1, 32'h20}) begin errors++; $display("FAIL post_ar: got v=%b a=%h expected v=1 a=00000020", m_arvalid, m_araddr); end
        s_arvalid = 1'b0;
        m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00; m_rvalid = 1'b1;
        step();
        checks++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin errors++; $display("FAIL post_r: got v=%b r=%b d=%h expected v=1 r=00 d=deadbeef", s_rvalid, s_rresp, s_rdata); end
        m_rvalid = 1'b0;
        step();
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL post_r_once: got %b expected 0", s_rvalid); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_aw_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
